// File: rtl/asconp_iter_lut_pkg.sv
// Shared types, constants and helpers for the iterative Ascon permutation core.
package asconp_pkg;

  localparam int unsigned MAX_ROUNDS = 12;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } asconp_state_t;

  typedef logic [0:31][4:0] sbox_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } asconp_fsm_t;

  localparam sbox_t SBOX_DEFAULT = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [7:0] rc(input logic [3:0] r);
    return {4'hF - r, r};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/asconp_iter_lut_if.sv
// Handshake, state and LUT-programming bundle between mode controller and permutation core.
interface asconp_iter_lut_if;
  logic        start_i;
  logic [3:0]  rounds_i;
  logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
  logic        ready_o;
  logic        valid_o;
  logic        out_ack_i;
  logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
  logic        sbox_we_i;
  logic [4:0]  sbox_addr_i;
  logic [4:0]  sbox_data_i;
  logic        sbox_err_o;

  modport master (
    output start_i, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ack_i,
    output sbox_we_i, sbox_addr_i, sbox_data_i,
    input  ready_o, valid_o, x0_o, x1_o, x2_o, x3_o, x4_o, sbox_err_o
  );

  modport slave (
    input  start_i, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ack_i,
    input  sbox_we_i, sbox_addr_i, sbox_data_i,
    output ready_o, valid_o, x0_o, x1_o, x2_o, x3_o, x4_o, sbox_err_o
  );
endinterface

// File: rtl/asconp_iter_lut_round.sv
// One combinational Ascon round using a supplied S-box table; bypass when not enabled.
module asconp_round
  import asconp_pkg::*;
(
  input  asconp_state_t s_in,
  input  logic [3:0]    r,
  input  logic          en,
  input  sbox_t         lut,
  output asconp_state_t s_out
);

  asconp_state_t c, s, l;
  logic [4:0]    idx, sv;

  always_comb begin
    c    = s_in;
    c.x2 = s_in.x2 ^ {56'd0, rc(r)};
    s    = '0;
    idx  = '0;
    sv   = '0;
    // Bit-sliced substitution: column i of the five words forms one LUT address.
    for (int unsigned i = 0; i < 64; i++) begin
      idx     = {c.x0[i], c.x1[i], c.x2[i], c.x3[i], c.x4[i]};
      sv      = lut[idx];
      s.x0[i] = sv[4];
      s.x1[i] = sv[3];
      s.x2[i] = sv[2];
      s.x3[i] = sv[1];
      s.x4[i] = sv[0];
    end
    l    = '0;
    l.x0 = s.x0 ^ ror64(s.x0, 19) ^ ror64(s.x0, 28);
    l.x1 = s.x1 ^ ror64(s.x1, 61) ^ ror64(s.x1, 39);
    l.x2 = s.x2 ^ ror64(s.x2, 1)  ^ ror64(s.x2, 6);
    l.x3 = s.x3 ^ ror64(s.x3, 10) ^ ror64(s.x3, 17);
    l.x4 = s.x4 ^ ror64(s.x4, 7)  ^ ror64(s.x4, 41);
    s_out = en ? l : s_in;
  end

endmodule

// File: rtl/asconp_iter_lut.sv
// Iterative Ascon permutation: 1..12 rounds, UROL rounds per clock, reprogrammable S-box LUT.
module asconp_iter_lut
  import asconp_pkg::*;
#(
  parameter int unsigned UROL       = 1,
  parameter bit          SBOX_WR_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  asconp_iter_lut_if.slave bus
);

  localparam logic [3:0] UROL_W = 4'(UROL);
  localparam logic [3:0] MAX_W  = 4'(MAX_ROUNDS);

  asconp_fsm_t   fsm_q;
  asconp_state_t st_q;
  asconp_state_t chain [UROL+1];
  sbox_t         lut_q;
  logic [3:0]    r_q, rem_q, r_cnt, k;
  logic          ready_q, valid_q, err_q;

  assign r_cnt    = (bus.rounds_i > MAX_W) ? MAX_W : bus.rounds_i;
  assign k        = (rem_q < UROL_W) ? rem_q : UROL_W;
  assign chain[0] = st_q;

  // Stage j is live only while j rounds remain; trailing stages pass the state through.
  for (genvar j = 0; j < UROL; j++) begin : g_round
    asconp_round u_round (
      .s_in  (chain[j]),
      .r     (r_q + 4'(j)),
      .en    (4'(j) < rem_q),
      .lut   (lut_q),
      .s_out (chain[j+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      st_q    <= '0;
      r_q     <= '0;
      rem_q   <= '0;
      lut_q   <= SBOX_DEFAULT;
    end else begin
      err_q <= 1'b0;
      if (bus.sbox_we_i) begin
        if (fsm_q == IDLE) begin
          if (SBOX_WR_EN) lut_q[bus.sbox_addr_i] <= bus.sbox_data_i;
        end else begin
          err_q <= 1'b1;
        end
      end
      case (fsm_q)
        IDLE: begin
          if (bus.start_i) begin
            st_q    <= {bus.x0_i, bus.x1_i, bus.x2_i, bus.x3_i, bus.x4_i};
            r_q     <= MAX_W - r_cnt;
            rem_q   <= r_cnt;
            ready_q <= 1'b0;
            if (r_cnt == 4'd0) begin
              fsm_q   <= DONE;
              valid_q <= 1'b1;
            end else begin
              fsm_q <= RUN;
            end
          end
        end
        RUN: begin
          st_q  <= chain[UROL];
          r_q   <= r_q + k;
          rem_q <= rem_q - k;
          if (rem_q <= UROL_W) begin
            fsm_q   <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ack_i) begin
            fsm_q   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign bus.ready_o    = ready_q;
  assign bus.valid_o    = valid_q;
  assign bus.sbox_err_o = err_q;
  assign bus.x0_o       = st_q.x0;
  assign bus.x1_o       = st_q.x1;
  assign bus.x2_o       = st_q.x2;
  assign bus.x3_o       = st_q.x3;
  assign bus.x4_o       = st_q.x4;

endmodule

// File: tb/tb_asconp_iter_lut.sv
// Random-state checks of two core configurations (UROL=1 and UROL=3) against a behavioural Ascon model.
module tb_asconp_iter_lut;

  typedef logic [4:0][63:0] st5_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, ack = 1'b0, we = 1'b0;
  logic [3:0] rounds = '0;
  logic [4:0] addr = '0, data = '0;
  st5_t       x_in = '0;

  asconp_iter_lut_if b1 ();
  asconp_iter_lut_if b3 ();

  assign b1.start_i = start;  assign b3.start_i = start;
  assign b1.rounds_i = rounds; assign b3.rounds_i = rounds;
  assign b1.x0_i = x_in[0]; assign b1.x1_i = x_in[1]; assign b1.x2_i = x_in[2];
  assign b1.x3_i = x_in[3]; assign b1.x4_i = x_in[4];
  assign b3.x0_i = x_in[0]; assign b3.x1_i = x_in[1]; assign b3.x2_i = x_in[2];
  assign b3.x3_i = x_in[3]; assign b3.x4_i = x_in[4];
  assign b1.out_ack_i = ack;   assign b3.out_ack_i = ack;
  assign b1.sbox_we_i = we;    assign b3.sbox_we_i = we;
  assign b1.sbox_addr_i = addr; assign b3.sbox_addr_i = addr;
  assign b1.sbox_data_i = data; assign b3.sbox_data_i = data;

  asconp_iter_lut #(.UROL(1), .SBOX_WR_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  asconp_iter_lut #(.UROL(3), .SBOX_WR_EN(1'b1)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  logic [319:0] out1, out3;
  assign out1 = {b1.x0_o, b1.x1_o, b1.x2_o, b1.x3_o, b1.x4_o};
  assign out3 = {b3.x0_o, b3.x1_o, b3.x2_o, b3.x3_o, b3.x4_o};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model: the Ascon round described directly with arrays and plain arithmetic.
  logic [4:0] model_sb [32];
  localparam logic [4:0] ASCON_SB [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
  localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic st5_t ref_perm(input st5_t s, input int rq);
    st5_t x, t;
    int nr, idx;
    logic [4:0] v;
    x  = s;
    nr = (rq > 12) ? 12 : rq;
    for (int r = 12 - nr; r < 12; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      t = '0;
      for (int b = 0; b < 64; b++) begin
        idx = 16 * x[0][b] + 8 * x[1][b] + 4 * x[2][b] + 2 * x[3][b] + x[4][b];
        v = model_sb[idx];
        for (int w = 0; w < 5; w++) t[w][b] = v[4 - w];
      end
      for (int w = 0; w < 5; w++) x[w] = t[w] ^ rotr(t[w], ROT_A[w]) ^ rotr(t[w], ROT_B[w]);
    end
    return x;
  endfunction

  function automatic logic [319:0] flat(input st5_t s);
    return {s[0], s[1], s[2], s[3], s[4]};
  endfunction

  function automatic st5_t rand_state();
    st5_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a permutation on both cores, wait for both results, check latency and data.
  // err_at >= 0 issues a LUT write to entry 3 that many cycles after accept.
  task automatic run_perm(input st5_t s, input int rq, input int err_at);
    int c1, c3, nr;
    bit rdy_bad;
    st5_t e;
    nr = (rq > 12) ? 12 : rq;
    e  = ref_perm(s, rq);
    x_in = s; rounds = 4'(rq); start = 1'b1;
    tick();
    start = 1'b0;
    c1 = -1; c3 = -1; rdy_bad = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (b1.ready_o || b3.ready_o) rdy_bad = 1'b1;
      if (c1 < 0 && b1.valid_o) c1 = cyc;
      if (c3 < 0 && b3.valid_o) c3 = cyc;
      if (err_at >= 0 && cyc == err_at + 1) begin
        check("err_pulse_u1", 320'(b1.sbox_err_o), 320'(1));
        check("err_pulse_u3", 320'(b3.sbox_err_o), 320'(1));
      end
      if (err_at >= 0 && cyc == err_at + 2) begin
        check("err_clear_u1", 320'(b1.sbox_err_o), 320'(0));
        check("err_clear_u3", 320'(b3.sbox_err_o), 320'(0));
      end
      if (c1 >= 0 && c3 >= 0 && (err_at < 0 || cyc > err_at + 2)) break;
      we = (err_at >= 0 && cyc == err_at);
      addr = 5'd3; data = 5'h00;
      tick();
    end
    we = 1'b0;
    check("latency_u1", 320'(c1), 320'(nr));
    check("latency_u3", 320'(c3), 320'((nr + 2) / 3));
    check("ready_low", 320'(rdy_bad), 320'(0));
    check("result_u1", out1, flat(e));
    check("result_u3", out3, flat(e));
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ready_after_ack", 320'({b1.ready_o, b3.ready_o, b1.valid_o, b3.valid_o}), 320'(4'b1100));
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_flags"}, 320'({b1.ready_o, b1.valid_o, b1.sbox_err_o,
                                 b3.ready_o, b3.valid_o, b3.sbox_err_o}), 320'(6'b100100));
    check({tag, "_out_u1"}, out1, '0);
    check({tag, "_out_u3"}, out3, '0);
  endtask

  initial begin
    st5_t s, held;
    logic [319:0] snap1, snap3;
    for (int i = 0; i < 32; i++) model_sb[i] = ASCON_SB[i];

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_idle_reset("reset");

    run_perm(rand_state(), 12, -1); do_ack();
    run_perm(rand_state(), 8, -1);  do_ack();
    s = rand_state();
    run_perm(s, 0, -1);
    check("r0_passthrough", out1, flat(s));
    do_ack();
    run_perm(rand_state(), 15, -1); do_ack();
    for (int n = 0; n < 4; n++) begin
      run_perm(rand_state(), int'($urandom_range(1, 15)), -1);
      do_ack();
    end

    // Reprogram LUT[0] in IDLE, then p1 on the zero state.
    we = 1'b1; addr = 5'd0; data = 5'h1f;
    tick();
    we = 1'b0;
    model_sb[0] = 5'h1f;
    check("idle_write_no_err", 320'({b1.sbox_err_o, b3.sbox_err_o}), 320'(0));
    run_perm('0, 1, -1); do_ack();

    // Write during RUN is dropped: result still uses table with LUT[3] = 5'h14.
    run_perm(rand_state(), 12, 2); do_ack();

    // Hold the result in DONE with start asserted and different inputs.
    run_perm(rand_state(), 12, -1);
    snap1 = out1; snap3 = out3;
    held = rand_state();
    x_in = held; rounds = 4'd3; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_flags", 320'({b1.valid_o, b3.valid_o, b1.ready_o, b3.ready_o}), 320'(4'b1100));
      check("hold_out_u1", out1, snap1);
      check("hold_out_u3", out3, snap3);
    end
    start = 1'b0;
    do_ack();

    // Reset mid-RUN aborts and restores the default table.
    x_in = rand_state(); rounds = 4'd12; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_reset("midrun_reset");
    for (int i = 0; i < 32; i++) model_sb[i] = ASCON_SB[i];
    run_perm('0, 1, -1); do_ack();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
